one_bit_adder: RTL and testbench
================================

// Module: one_bit_adder
//
// PURPOSE
// - Single-bit full adder: sum/cout of a + b + cin.
// - Primary outputs are purely combinational (zero latency).
// - Optional registered copies on clk let downstream pipelined logic take a timed result.
// - Leaf cell for ripple-carry adders and arithmetic datapaths.
//
// PARAMETERS
// - REG_OUT  1  1: sum_q/cout_q register sum/cout on clk. 0: sum_q/cout_q tied to 0, no flops.
//
// PORTS
// - clk     in   1  clock; used only by registered outputs
// - rst_n   in   1  asynchronous active-low reset; clears registered outputs only
// - a       in   1  addend bit
// - b       in   1  addend bit
// - cin     in   1  carry in
// - sum     out  1  combinational sum = a ^ b ^ cin
// - cout    out  1  combinational carry = (a & b) | (cin & (a ^ b))
// - sum_q   out  1  sum registered on rising clk (REG_OUT=1)
// - cout_q  out  1  cout registered on rising clk (REG_OUT=1)
//
// BEHAVIOUR
// - One clock domain: clk. Reset is asynchronous and active-low: rst_n.
// - {cout,sum} equals the 2-bit result of a + b + cin, for all 8 input combinations.
// - sum and cout:
//   - 0-cycle latency; settle within one simulation time unit of any input change.
//   - Independent of clk and rst_n; valid while in reset and with clk idle or floating.
//   - No X on outputs when a, b and cin are all known.
// - Implementation: two half adders plus OR.
//   - p = a ^ b, g = a & b
//   - sum = p ^ cin, cout = g | (p & cin)
// - Registered path (REG_OUT=1):
//   - rst_n low (asynchronous): sum_q = 0 and cout_q = 0 immediately.
//   - Flops held at 0 while rst_n is low.
//   - First rising clk with rst_n high captures the current {cout,sum}. Latency is 1 cycle.
//   - rst_n asserted mid-operation: clears sum_q/cout_q at once; sum/cout are unaffected.
//   - rst_n deassert coincident with clk edge: that edge does not capture; the next edge does.
// - No internal state besides the two output flops. No handshake. No overflow beyond cout.
//
// TESTING
// - Exhaustive combinational sweep:
//   - Count {a,b,cin} 0..7; check {cout,sum} = a+b+cin one time unit after each change.
//   - Values: 000->00, 001->01, 010->01, 011->10, 100->01, 101->10, 110->10, 111->11.
// - Clock floating / rst_n low: a=1,b=1,cin=0 -> sum=0, cout=1 with no clk edges applied.
// - Registered latency:
//   - Release rst_n, set a=1,b=0,cin=1 -> cout=1,sum=0 immediately.
//   - sum_q/cout_q stay 0 until the next rising clk, then become 0/1.
// - Async reset mid-run:
//   - With sum_q=1, assert rst_n=0 between clk edges -> sum_q=0, cout_q=0 before the next edge.
//   - sum still tracks inputs during reset.
// - Back-to-back inputs: change inputs every cycle (111, 000, 011) -> sum_q/cout_q follow one cycle behind: 11, 00, 10.
// - REG_OUT=0 build: sum_q = cout_q = 0 for all inputs and clocks; sum/cout pass the exhaustive sweep.

Source files
------------

// File: rtl/one_bit_adder.sv
// Full adder: combinational sum/cout plus optional flopped copies (sum_q/cout_q).
// Latency 0 on sum/cout, 1 clk on sum_q/cout_q; no handshake, never stalls.
module one_bit_adder #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic sum_q,
  output logic cout_q
);

  logic w_p;
  logic w_g;

  // Two half adders: propagate/generate from a,b, then fold in the carry.
  assign w_p  = a ^ b;
  assign w_g  = a & b;
  assign sum  = w_p ^ cin;
  assign cout = w_g | (w_p & cin);

  generate
    if (REG_OUT) begin : g_reg
      logic r_sum;
      logic r_cout;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum  <= 1'b0;
          r_cout <= 1'b0;
        end else begin
          r_sum  <= sum;
          r_cout <= cout;
        end
      end

      assign sum_q  = r_sum;
      assign cout_q = r_cout;
    end else begin : g_noreg
      // Clock and reset have no load in this build.
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign sum_q    = 1'b0;
      assign cout_q   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_one_bit_adder.sv
// Scoreboard bench for one_bit_adder: registered and unregistered builds side by side.
module tb_one_bit_adder;

  logic clk;
  logic clk_en;
  logic rst_n;
  logic a, b, cin;
  logic sum, cout, sum_q, cout_q;
  logic sum0, cout0, sum_q0, cout_q0;

  int tests;
  int fails;
  logic [1:0] exp_q[$];

  one_bit_adder #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .sum_q(sum_q), .cout_q(cout_q)
  );

  one_bit_adder #(.REG_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum0), .cout(cout0), .sum_q(sum_q0), .cout_q(cout_q0)
  );

  // Gated clock so the first phase can run with no edges at all.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  function automatic logic [1:0] model(input logic ia, input logic ib, input logic ic);
    int t;
    t = int'(ia) + int'(ib) + int'(ic);
    return t[1:0];
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (a=%b b=%b cin=%b t=%0t)", name, act, exp, a, b, cin, $time);
    end
  endtask

  // Applies inputs, checks both combinational paths, and queues the flopped result.
  task automatic drive(input logic ia, input logic ib, input logic ic, input bit push);
    a = ia; b = ib; cin = ic;
    #1;
    check("comb", {cout, sum}, model(ia, ib, ic));
    check("comb_noreg", {cout0, sum0}, model(ia, ib, ic));
    if (push) exp_q.push_back(model(ia, ib, ic));
  endtask

  // Monitor: after each rising edge out of reset, the oldest queued result must be on the flops.
  always @(posedge clk) begin
    #1;
    check("noreg_q_zero", {cout_q0, sum_q0}, 2'b00);
    if (rst_n && exp_q.size() > 0) begin
      check("reg_q", {cout_q, sum_q}, exp_q.pop_front());
    end
  end

  initial begin
    logic [2:0] v;
    tests  = 0;
    fails  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    a = 1'b0; b = 1'b0; cin = 1'b0;
    #2;
    check("reset_q", {cout_q, sum_q}, 2'b00);

    // Exhaustive sweep with the clock idle and reset held.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[2], v[1], v[0], 1'b0);
      check("sweep_noreg_q", {cout_q0, sum_q0}, 2'b00);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_clk_110", {cout, sum}, 2'b10);
    check("reset_q_idle", {cout_q, sum_q}, 2'b00);

    // Registered latency: result appears only after the next rising edge.
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("latency_comb", {cout, sum}, 2'b10);
    check("latency_q_hold", {cout_q, sum_q}, 2'b00);
    @(posedge clk); #2;
    check("latency_q_after", {cout_q, sum_q}, 2'b10);

    // Back-to-back inputs, one per cycle.
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b1);

    // Async reset between edges clears the flops at once; comb path keeps working.
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #2;
    check("pre_reset_q", {cout_q, sum_q}, 2'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset_q", {cout_q, sum_q}, 2'b00);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("in_reset_comb", {cout, sum}, 2'b10);
    @(posedge clk); #2;
    check("held_in_reset", {cout_q, sum_q}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, occasionally holding inputs across cycles.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0)
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      else
        drive(a, b, cin, 1'b1);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
